// File: rtl/mem_access_pkg.sv
// mem_access_pkg: size encodings, FSM state type and wait-counter sizing for mem_access_unit
package mem_access_pkg;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam int MEM_LAT_MAX = 15;
  localparam int CNT_W = $clog2(MEM_LAT_MAX + 1);
  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_e;
endpackage

// File: rtl/mem_access_unit_lane_align.sv
// mem_lane_align: combinational little-endian lane logic for the load/store sequencer
//   size_i  access size (SZ_BYTE/SZ_HALF/word)
//   off_i   byte offset addr[1:0]; a half access uses off_i[1] only
//   sign_i  sign-extend loaded sub-word value
//   word_i  word read from memory
//   wdata_i right-aligned store data
//   ldata_o extracted and extended load result
//   sdata_o word_i with the target lanes replaced by wdata_i
module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  off_i,
  input  logic        sign_i,
  input  logic [31:0] word_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] ldata_o,
  output logic [31:0] sdata_o
);
  logic [4:0]  sh;
  logic [31:0] lsh, mask;
  always_comb begin
    sh      = size_i == SZ_BYTE ? {off_i, 3'b000} : size_i == SZ_HALF ? {off_i[1], 4'b0000} : 5'd0;
    lsh     = word_i >> sh;
    ldata_o = size_i == SZ_BYTE ? {{24{sign_i & lsh[7]}}, lsh[7:0]} :
              size_i == SZ_HALF ? {{16{sign_i & lsh[15]}}, lsh[15:0]} : word_i;
    mask    = size_i == SZ_BYTE ? 32'h0000_00FF << sh : size_i == SZ_HALF ? 32'h0000_FFFF << sh : 32'hFFFF_FFFF;
    sdata_o = (word_i & ~mask) | ((wdata_i << sh) & mask);
  end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store sequencer for a word-wide data memory, sub-word stores via read-modify-write
//   clk_i, rst_n_i           clock, asynchronous active-low reset
//   req_i/we_i/size_i/sign_i/addr_i/wdata_i  pipeline request, sampled only while idle
//   ack_o/rdata_o/err_o/busy_o               completion pulse, load result, misalign flag, stall
//   mem_*                                    word-aligned memory port
//   `define MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of ignoring low address bits
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int MEM_LAT = 1,
  parameter int ADDR_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [1:0]        size_i,
  input  logic              sign_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic              ack_o,
  output logic [31:0]       rdata_o,
  output logic              err_o,
  output logic              busy_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_writedata_o,
  output logic              mem_memread_o,
  output logic              mem_memwrite_o,
  input  logic [31:0]       mem_readdata_i
);
  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d, sign_q, sign_d, err_q, err_d;
  logic [1:0]        size_q, size_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d, rdata_q, rdata_d;
  logic [31:0]       ldata, sdata;
  logic              mis;
`ifdef MISALIGN_TRAP_EN
  assign mis = size_i == SZ_HALF ? addr_i[0] : size_i[1] & |addr_i[1:0];
`else
  assign mis = 1'b0;
`endif
  mem_lane_align u_align (
    .size_i (size_q),
    .off_i  (addr_q[1:0]),
    .sign_i (sign_q),
    .word_i (mem_readdata_i),
    .wdata_i(wdata_q),
    .ldata_o(ldata),
    .sdata_o(sdata)
  );
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      sign_q  <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      sign_q  <= sign_d;
      err_q   <= err_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end
  // wdata_q doubles as the merged write word once a sub-word store has read its target
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    sign_d  = sign_q;
    err_d   = err_q;
    size_d  = size_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: if (req_i) begin
        we_d    = we_i;
        sign_d  = sign_i;
        size_d  = size_i;
        addr_d  = addr_i;
        wdata_d = wdata_i;
        err_d   = mis;
        cnt_d   = CNT_W'(MEM_LAT - 1);
        rdata_d = mis ? '0 : rdata_q;
        state_d = mis ? RESP : (we_i && size_i[1]) ? WRITE : READ;
      end
      READ: if (cnt_q == '0) begin
        state_d = we_q ? WRITE : RESP;
        wdata_d = we_q ? sdata : wdata_q;
        rdata_d = we_q ? rdata_q : ldata;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
      WRITE:   state_d = RESP;
      default: state_d = IDLE;
    endcase
  end
  assign ack_o           = state_q == RESP;
  assign busy_o          = state_q != IDLE;
  assign err_o           = ack_o & err_q;
  assign rdata_o         = rdata_q;
  assign mem_memread_o   = state_q == READ;
  assign mem_memwrite_o  = state_q == WRITE;
  assign mem_addr_o      = (mem_memread_o || mem_memwrite_o) ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign mem_writedata_o = mem_memwrite_o ? wdata_q : '0;
endmodule
